// File: rtl/outport_vc_credit_tracker.sv
// -----------------------------------------------------------------------------
// outport_vc_credit_tracker
//
// Per-output-port bookkeeping for the downstream virtual channels. For every
// VC it keeps a free-slot (credit) counter and an IDLE/ACTIVE packet state,
// and publishes registered `credit` / `vc_isNew` vectors for the VC priority
// checkers of the same output port.
//
// Ports
//   clk          in   clock, all state on the rising edge
//   rst          in   synchronous active-high reset
//   flit_sent    in   a flit leaves the port this cycle
//   sent_vc      in   VC of the sent flit
//   sent_head    in   sent flit is a head
//   sent_tail    in   sent flit is a tail (head+tail = single-flit packet)
//   credit_valid in   one credit returned from downstream this cycle
//   credit_vc    in   VC of the returned credit
//   credit       out  bit i: VC i has at least one free downstream slot
//   vc_isNew     out  bit i: VC i may accept a new packet
//   credit_err   out  sticky overflow/underflow/protocol error flag
// -----------------------------------------------------------------------------
module outport_vc_credit_tracker #(
  parameter int VC_NUM    = 4,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3,
  parameter int ATOMIC    = 1,
  parameter int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flit_sent,
  input  logic [VC_SIZE-1:0] sent_vc,
  input  logic               sent_head,
  input  logic               sent_tail,
  input  logic               credit_valid,
  input  logic [VC_SIZE-1:0] credit_vc,
  output logic [VC_NUM-1:0]  credit,
  output logic [VC_NUM-1:0]  vc_isNew,
  output logic               credit_err
);

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  logic [CNT_W-1:0] cnt_q   [VC_NUM];
  logic [CNT_W-1:0] cnt_d   [VC_NUM];
  vc_state_e        state_q [VC_NUM];
  vc_state_e        state_d [VC_NUM];
  logic [VC_NUM-1:0] credit_q, credit_d;
  logic [VC_NUM-1:0] is_new_q, is_new_d;
  logic              err_q, err_d;

  logic              sent_ok, credit_ok;
  logic [VC_NUM-1:0] dec_v, inc_v;

  // Events naming a VC beyond VC_NUM are dropped and only flag an error.
  assign sent_ok   = int'(sent_vc) < VC_NUM;
  assign credit_ok = int'(credit_vc) < VC_NUM;

  always_comb begin
    for (int i = 0; i < VC_NUM; i++) begin
      dec_v[i] = flit_sent && sent_ok && (sent_vc == VC_SIZE'(i));
      inc_v[i] = credit_valid && credit_ok && (credit_vc == VC_SIZE'(i));
    end
  end

  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves it unassigned (no latches).
    err_d = err_q;
    for (int i = 0; i < VC_NUM; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
    end

    if (flit_sent && !sent_ok)      err_d = 1'b1;
    if (credit_valid && !credit_ok) err_d = 1'b1;

    for (int i = 0; i < VC_NUM; i++) begin
      // A flit and a credit on the same VC cancel, even at 0 or full.
      if (dec_v[i] && !inc_v[i]) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end
      if (inc_v[i] && !dec_v[i]) begin
        if (cnt_q[i] == CNT_FULL) err_d = 1'b1;
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end

      if (dec_v[i]) begin
        case (state_q[i])
          VC_IDLE: begin
            if (!sent_head)     err_d = 1'b1;        // body/tail with no packet open
            else if (!sent_tail) state_d[i] = VC_ACTIVE;
          end
          VC_ACTIVE: begin
            if (sent_head)      err_d = 1'b1;        // new head inside an open packet
            else if (sent_tail) state_d[i] = VC_IDLE;
          end
          default: state_d[i] = VC_IDLE;
        endcase
      end
    end

    // Outputs are computed from next state so they line up with the counters
    // one cycle after the event, with no combinational input-to-output path.
    for (int i = 0; i < VC_NUM; i++) begin
      credit_d[i] = (cnt_d[i] != '0);
      is_new_d[i] = (state_d[i] == VC_IDLE) && ((ATOMIC == 0) || (cnt_d[i] == CNT_FULL));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter arrays are real state that must start full, so they are reset (not a RAM).
      for (int i = 0; i < VC_NUM; i++) begin
        cnt_q[i]   <= CNT_FULL;
        state_q[i] <= VC_IDLE;
      end
      credit_q <= '1;
      is_new_q <= '1;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < VC_NUM; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
      credit_q <= credit_d;
      is_new_q <= is_new_d;
      err_q    <= err_d;
    end
  end

  assign credit     = credit_q;
  assign vc_isNew   = is_new_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_outport_vc_credit_tracker.sv
module tb_outport_vc_credit_tracker;

  logic       clk;
  logic       rst;
  logic       flit_sent;
  logic [1:0] sent_vc;
  logic       sent_head;
  logic       sent_tail;
  logic       credit_valid;
  logic [1:0] credit_vc;
  logic [3:0] credit;
  logic [3:0] vc_isNew;
  logic       credit_err;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] credit;
    logic [3:0] is_new;
    logic       err;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference state kept by the bench
  int m_cnt [4];
  bit m_act [4];
  bit m_err;

  outport_vc_credit_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .flit_sent    (flit_sent),
    .sent_vc      (sent_vc),
    .sent_head    (sent_head),
    .sent_tail    (sent_tail),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .credit       (credit),
    .vc_isNew     (vc_isNew),
    .credit_err   (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_apply(input bit fs, input int svc, input bit hd, input bit tl,
                             input bit cv, input int cvc, input bit r, input string tag);
    exp_t e;
    if (r) begin
      for (int v = 0; v < 4; v++) begin
        m_cnt[v] = 4;
        m_act[v] = 0;
      end
      m_err = 0;
    end else begin
      for (int v = 0; v < 4; v++) begin
        bit d, u;
        d = fs && (svc == v);
        u = cv && (cvc == v);
        if (d && !u) begin
          if (m_cnt[v] == 0) m_err = 1; else m_cnt[v]--;
        end
        if (u && !d) begin
          if (m_cnt[v] == 4) m_err = 1; else m_cnt[v]++;
        end
        if (d) begin
          if (hd && m_act[v])       m_err = 1;
          else if (!hd && !m_act[v]) m_err = 1;
          else if (hd && !tl)       m_act[v] = 1;
          else if (tl)              m_act[v] = 0;
        end
      end
    end
    for (int v = 0; v < 4; v++) begin
      e.credit[v] = (m_cnt[v] != 0);
      e.is_new[v] = !m_act[v] && (m_cnt[v] == 4);
    end
    e.err = m_err;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive, predict, then compare one cycle later.
  task automatic drive(input bit fs, input logic [1:0] svc, input bit hd, input bit tl,
                       input bit cv, input logic [1:0] cvc, input bit r, input string tag);
    exp_t e;
    @(negedge clk);
    rst          = r;
    flit_sent    = fs;
    sent_vc      = svc;
    sent_head    = hd;
    sent_tail    = tl;
    credit_valid = cv;
    credit_vc    = cvc;
    model_apply(fs, int'(svc), hd, tl, cv, int'(cvc), r, tag);
    @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      if (credit !== e.credit || vc_isNew !== e.is_new || credit_err !== e.err) begin
        miscompares++;
        $display("FAIL %s: got credit=%b isNew=%b err=%b, expected credit=%b isNew=%b err=%b",
                 e.tag, credit, vc_isNew, credit_err, e.credit, e.is_new, e.err);
      end
    end
  endtask

  task automatic idle(input string tag);
    drive(0, 2'd0, 0, 0, 0, 2'd0, 0, tag);
  endtask

  task automatic do_reset(input string tag);
    drive(0, 2'd0, 0, 0, 0, 2'd0, 1, tag);
  endtask

  task automatic test_reset();
    do_reset("reset0");
    do_reset("reset1");
    idle("reset_idle");
    vectors++;
    if (credit !== 4'b1111 || vc_isNew !== 4'b1111 || credit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got %b/%b/%b, expected 1111/1111/0", credit, vc_isNew, credit_err);
    end
  endtask

  task automatic test_packet_vc2();
    drive(1, 2'd2, 1, 0, 0, 2'd0, 0, "pkt2_head");
    vectors++;
    if (vc_isNew[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL pkt2_active_isnew: got %b, expected 0", vc_isNew[2]);
    end
    drive(1, 2'd2, 0, 0, 0, 2'd0, 0, "pkt2_body");
    drive(1, 2'd2, 0, 1, 0, 2'd0, 0, "pkt2_tail");
    vectors++;
    if (credit[2] !== 1'b1 || vc_isNew[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL pkt2_after_tail: got credit=%b isNew=%b, expected 1/0", credit[2], vc_isNew[2]);
    end
    drive(0, 2'd0, 0, 0, 1, 2'd2, 0, "pkt2_cr1");
    drive(0, 2'd0, 0, 0, 1, 2'd2, 0, "pkt2_cr2");
    vectors++;
    if (vc_isNew[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL pkt2_not_drained: got %b, expected 0", vc_isNew[2]);
    end
    drive(0, 2'd0, 0, 0, 1, 2'd2, 0, "pkt2_cr3");
    vectors++;
    if (vc_isNew[2] !== 1'b1 || credit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL pkt2_drained: got isNew=%b err=%b, expected 1/0", vc_isNew[2], credit_err);
    end
  endtask

  task automatic test_last_credit_vc1();
    for (int k = 0; k < 4; k++) drive(1, 2'd1, 1, 1, 0, 2'd0, 0, $sformatf("vc1_single%0d", k));
    vectors++;
    if (credit[1] !== 1'b0 || credit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL vc1_empty: got credit=%b err=%b, expected 0/0", credit[1], credit_err);
    end
    drive(1, 2'd1, 1, 1, 0, 2'd0, 0, "vc1_underflow");
    vectors++;
    if (credit[1] !== 1'b0 || credit_err !== 1'b1) begin
      miscompares++;
      $display("FAIL vc1_underflow: got credit=%b err=%b, expected 0/1", credit[1], credit_err);
    end
    do_reset("vc1_clear");
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 4; k++) drive(1, 2'd0, 1, 1, 0, 2'd0, 0, $sformatf("vc0_drain%0d", k));
    drive(1, 2'd0, 1, 1, 1, 2'd0, 0, "vc0_cancel_at_zero");
    vectors++;
    if (credit[0] !== 1'b0 || credit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL vc0_cancel: got credit=%b err=%b, expected 0/0", credit[0], credit_err);
    end
    drive(0, 2'd0, 0, 0, 1, 2'd0, 0, "vc0_refill1");
    drive(1, 2'd3, 1, 1, 0, 2'd0, 0, "vc3_take1");
    drive(1, 2'd0, 1, 1, 1, 2'd3, 0, "vc0_send_vc3_credit");
    vectors++;
    if (credit[0] !== 1'b0 || vc_isNew[3] !== 1'b1 || credit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL split_vc: got credit0=%b isNew3=%b err=%b, expected 0/1/0",
               credit[0], vc_isNew[3], credit_err);
    end
  endtask

  task automatic test_overflow_and_protocol();
    drive(0, 2'd0, 0, 0, 1, 2'd3, 0, "vc3_overflow");
    vectors++;
    if (credit_err !== 1'b1 || vc_isNew[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL vc3_overflow: got err=%b isNew3=%b, expected 1/1", credit_err, vc_isNew[3]);
    end
    do_reset("proto_clear");
    drive(1, 2'd2, 1, 0, 0, 2'd0, 0, "proto_head1");
    drive(1, 2'd2, 1, 0, 0, 2'd0, 0, "proto_head2");
    vectors++;
    if (credit_err !== 1'b1) begin
      miscompares++;
      $display("FAIL head_on_active: got err=%b, expected 1", credit_err);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset("mid_pre");
    drive(1, 2'd2, 1, 0, 0, 2'd0, 0, "mid_head");
    drive(1, 2'd2, 0, 0, 0, 2'd0, 0, "mid_body");
    drive(1, 2'd1, 0, 0, 1, 2'd0, 0, "mid_bad_body");
    drive(1, 2'd2, 0, 1, 1, 2'd3, 1, "mid_rst_overrides");
    vectors++;
    if (credit !== 4'b1111 || vc_isNew !== 4'b1111 || credit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got %b/%b/%b, expected 1111/1111/0", credit, vc_isNew, credit_err);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int k = 0; k < 300; k++) begin
      bit r;
      r = ($urandom_range(0, 29) == 0);
      drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)), r,
            $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    rst = 1'b1; flit_sent = 1'b0; sent_vc = '0; sent_head = 1'b0; sent_tail = 1'b0;
    credit_valid = 1'b0; credit_vc = '0;
    test_reset();
    test_packet_vc2();
    test_last_credit_vc1();
    test_same_cycle();
    test_overflow_and_protocol();
    test_reset_mid_packet();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/outport_vc_credit_tracker.md
# outport_vc_credit_tracker

Per-output-port state keeper for the downstream virtual channels. It tracks how many buffer slots each downstream VC has free and whether each VC is idle or allocated to a packet in flight. It drives the `credit` and `vc_isNew` vectors consumed by `priority_vc_check_outport` / `ALL_priority_vc_check_outport` in the same output port. Its inputs are the flit leaving the port and the credit returns arriving from the downstream router.

## Interface
Parameters:
- `VC_NUM`, 4, number of VCs on the output link.
- `BUF_DEPTH`, 4, downstream buffer slots per VC; credit counter reset and maximum value.
- `CNT_W`, 3, credit counter width; must satisfy 2^CNT_W > BUF_DEPTH.
- `ATOMIC`, 1, when 1 a VC is reported new only if idle AND its credit count equals BUF_DEPTH (downstream fully drained).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flit_sent`  in  1  a flit leaves the port this cycle.
- `sent_vc`  in  `VC_SIZE_default`  VC of the sent flit.
- `sent_head`  in  1  sent flit is a head.
- `sent_tail`  in  1  sent flit is a tail; head+tail together means a single-flit packet.
- `credit_valid`  in  1  one credit returned this cycle.
- `credit_vc`  in  `VC_SIZE_default`  VC of the returned credit.
- `credit`  out  `VC_NUM`  bit i = VC i count > 0; bit 0 = VC 0, same ordering as the checker's `credit[0:VC_NUM-1]`.
- `vc_isNew`  out  `VC_NUM`  bit i = VC i free for a new packet.
- `credit_err`  out  1  sticky; set on overflow/underflow, cleared only by `rst`.

## Operation
- Per VC, one counter `cnt[i]` (CNT_W bits) and one 1-bit state: IDLE or ACTIVE.
- Counter update for VC i each cycle:
  - decrement if `flit_sent && sent_vc==i`;
  - increment if `credit_valid && credit_vc==i`;
  - both on the same VC: unchanged.
- Underflow: decrement with `cnt==0`. Counter holds at 0; `credit_err` is set.
- Overflow: increment with `cnt==BUF_DEPTH`. Counter holds at BUF_DEPTH; `credit_err` is set.
- Simultaneous decrement+increment at a boundary is not an error.
- State transitions, on `flit_sent` for `sent_vc`:
  - IDLE → ACTIVE on head without tail.
  - ACTIVE → IDLE on tail.
  - Head+tail: state stays IDLE.
  - Head arriving while ACTIVE: state stays ACTIVE; `credit_err` is set (protocol violation).
  - Body/tail arriving while IDLE: state unchanged; `credit_err` is set.
- `sent_vc`/`credit_vc` ≥ VC_NUM: the event is ignored and `credit_err` is set.
- Output equations (all registered):
  - `credit[i]` = next `cnt[i]` != 0.
  - `vc_isNew[i]` = next state IDLE && (ATOMIC==0 || next `cnt[i]`==BUF_DEPTH).
- Outputs do not depend combinationally on inputs in the same cycle, so there is no loop through the checker.

## Timing
- Reset (rst=1 at a clock edge) gives:
  - all `cnt`=BUF_DEPTH, all states IDLE;
  - `credit`=all 1, `vc_isNew`=all 1, `credit_err`=0.
- `rst` overrides any concurrent event in the same cycle.
- Reset mid-packet discards ACTIVE state and counts.
- Latency: an event sampled at edge N is reflected on the outputs after edge N (visible in cycle N+1). Exactly one cycle.
- At most one flit and one credit per cycle. Both may target the same or different VCs in the same cycle; both are applied.
- Last-credit boundary: with `cnt[i]`==1 and a flit sent on VC i, `credit[i]` is 0 from the next cycle. The checker therefore cannot select VC i again until a credit returns.
- Full return: when ATOMIC=1, after a tail the VC reasserts `vc_isNew` one cycle after the final credit brings `cnt` back to BUF_DEPTH.

## Test plan
- Reset, then idle: `credit`=4'b1111, `vc_isNew`=4'b1111, `credit_err`=0.
- Send a 3-flit packet on VC 2 (head, body, tail) with no credit returns:
  - `cnt[2]`=1, `credit[2]`=1;
  - `vc_isNew[2]`=0 while ACTIVE and stays 0 after the tail (ATOMIC=1);
  - return 3 credits on VC 2 → `vc_isNew[2]`=1 one cycle after the third.
- Send 4 single-flit packets on VC 1 → `credit[1]`=0 in the cycle after the 4th; a 5th send → `cnt` holds at 0 and `credit_err`=1.
- Same cycle: flit sent on VC 0 and credit on VC 0 with `cnt`=0 → `cnt` stays 0, no error; flit on VC 0 plus credit on VC 3 → `cnt[0]`−1 and `cnt[3]`+1 (or overflow error if `cnt[3]` is already 4).
- Credit on VC 3 at `cnt`=4 → `credit_err`=1, `cnt` stays 4; head on an already-ACTIVE VC → `credit_err`=1.
- Assert `rst` mid-packet on VC 2 → next cycle all outputs return to reset values, including `credit_err`=0.
